floo_credit_link_adapter: RTL and testbench

- Sits directly downstream of the narrow-wide chimney's per-class flit ports (floo_req/rsp/wide), between the chimney and the physical link or router.
- TX half converts the chimney's valid/ready flit stream into a credit-based link.
- RX half buffers incoming credit-based flits in a NumCredits-deep FIFO, presents them to the chimney as valid/ready, and returns one credit per consumed flit.
- One instance is used per physical channel (req, rsp, wide).

---
 rtl/floo_narrow_wide_pkg.sv | 22 ++
 rtl/floo_credit_counter.sv | 42 ++++
 rtl/floo_credit_link_adapter.sv | 115 +++++++++++
 tb/tb_floo_credit_link_adapter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/floo_narrow_wide_pkg.sv
// Shared flit payload types and per-channel credit depths for the narrow-wide NoC links.
// Every credit link adapter and VC link takes its types and depths from this package.
package floo_narrow_wide_pkg;

   localparam int unsigned ReqWidth  = 64;
   localparam int unsigned RspWidth  = 48;
   localparam int unsigned WideWidth = 512;

   typedef logic [ReqWidth-1:0]  floo_req_t;
   typedef logic [RspWidth-1:0]  floo_rsp_t;
   typedef logic [WideWidth-1:0] floo_wide_t;

   localparam int unsigned NumReqCredits  = 4;
   localparam int unsigned NumRspCredits  = 4;
   localparam int unsigned NumWideCredits = 8;

   // Pointer width for a buffer of n entries; a single-entry buffer still needs one bit.
   function automatic int unsigned ptr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/floo_credit_counter.sv
// Saturating up/down counter with init value, sticky overflow flag and nonzero flag.
// inc_i at MaxVal with no dec_i saturates and raises overflow_o.
module floo_credit_counter #(
   parameter int unsigned       Width   = 3,
   parameter logic [Width-1:0] InitVal = 4,
   parameter logic [Width-1:0] MaxVal  = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [Width-1:0] count_o,
   output logic             nonzero_o,
   output logic             overflow_o
);

   logic [Width-1:0] count_reg;
   logic             overflow_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_reg    <= InitVal;
         overflow_reg <= 1'b0;
      end else begin
         case ({inc_i, dec_i})
            2'b10: begin
               if (count_reg == MaxVal) overflow_reg <= 1'b1;
               else                     count_reg    <= count_reg + 1'b1;
            end
            2'b01: begin
               if (count_reg != '0) count_reg <= count_reg - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign count_o    = count_reg;
   assign nonzero_o  = (count_reg != '0);
   assign overflow_o = overflow_reg;

endmodule

// File: rtl/floo_credit_link_adapter.sv
// Bridges a chimney valid/ready flit port onto a credit-based physical link.
// TX spends one credit per sent flit; RX buffers up to NumCredits flits and returns a credit per pop.
module floo_credit_link_adapter
   import floo_narrow_wide_pkg::*;
#(
   parameter type         flit_t     = logic,
   parameter int unsigned NumCredits = 4,
   parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  flit_t               data_i,
   output logic                link_valid_o,
   output flit_t               link_data_o,
   input  logic                credit_i,
   input  logic                link_valid_i,
   input  flit_t               link_data_i,
   output logic                credit_o,
   output logic                valid_o,
   input  logic                ready_i,
   output flit_t               data_o,
   output logic [CntWidth-1:0] credits_o,
   output logic [1:0]          err_o
);

   localparam int unsigned         PtrWidth = ptr_width(NumCredits);
   localparam logic [CntWidth-1:0] Depth    = CntWidth'(NumCredits);
   localparam logic [PtrWidth-1:0] LastIdx  = PtrWidth'(NumCredits - 1);

   // ---------------- TX half ----------------
   logic send;
   logic err_credit;

   assign send = valid_i && ready_o;

   floo_credit_counter #(
      .Width  (CntWidth),
      .InitVal(Depth),
      .MaxVal (Depth)
   ) i_tx_credits (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_i     (credit_i),
      .dec_i     (send),
      .count_o   (credits_o),
      .nonzero_o (ready_o),
      .overflow_o(err_credit)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         link_valid_o <= 1'b0;
         link_data_o  <= '0;
      end else begin
         link_valid_o <= send;
         if (send) link_data_o <= data_i;
      end
   end

   // ---------------- RX half ----------------
   // The fill counter has the same saturate-and-flag semantics as the credit
   // counter: a push into a full FIFO without a pop is dropped and flagged.
   logic                push;
   logic                pop;
   logic                full;
   logic                push_accept;
   logic                err_fifo;
   logic [CntWidth-1:0] fill_count;
   logic [PtrWidth-1:0] wr_ptr_reg;
   logic [PtrWidth-1:0] rd_ptr_reg;
   flit_t               mem [NumCredits];

   assign push        = link_valid_i;
   assign pop         = valid_o && ready_i;
   assign full        = (fill_count == Depth);
   assign push_accept = push && (!full || pop);

   floo_credit_counter #(
      .Width  (CntWidth),
      .InitVal('0),
      .MaxVal (Depth)
   ) i_rx_fill (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .inc_i     (push),
      .dec_i     (pop),
      .count_o   (fill_count),
      .nonzero_o (valid_o),
      .overflow_o(err_fifo)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         credit_o   <= 1'b0;
      end else begin
         credit_o <= pop;
         if (push_accept) wr_ptr_reg <= (wr_ptr_reg == LastIdx) ? '0 : wr_ptr_reg + 1'b1;
         if (pop)         rd_ptr_reg <= (rd_ptr_reg == LastIdx) ? '0 : rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_accept) mem[wr_ptr_reg] <= link_data_i;
   end

   // Stale entries stay hidden so an empty FIFO always presents zero.
   assign data_o = valid_o ? mem[rd_ptr_reg] : '0;

   assign err_o = {err_fifo, err_credit};

endmodule

// File: tb/tb_floo_credit_link_adapter.sv
// Directed bench for floo_credit_link_adapter with a queue-based reference model
// compared against the outputs on every falling edge.
module tb_floo_credit_link_adapter;

   localparam int N = 4;
   typedef logic [7:0] flit_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid_i, ready_o, link_valid_o, credit_i, link_valid_i, credit_o, valid_o, ready_i;
   flit_t      data_i, link_data_o, link_data_i, data_o;
   logic [2:0] credits_o;
   logic [1:0] err_o;

   logic  loop, rx_valid_drv, credit_drv;
   flit_t rx_data_drv;

   assign link_valid_i = loop ? link_valid_o : rx_valid_drv;
   assign link_data_i  = loop ? link_data_o  : rx_data_drv;
   assign credit_i     = loop ? credit_o     : credit_drv;

   always #5 clk = ~clk;

   floo_credit_link_adapter #(
      .flit_t    (flit_t),
      .NumCredits(N)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_i      (data_i),
      .link_valid_o(link_valid_o),
      .link_data_o (link_data_o),
      .credit_i    (credit_i),
      .link_valid_i(link_valid_i),
      .link_data_i (link_data_i),
      .credit_o    (credit_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .data_o      (data_o),
      .credits_o   (credits_o),
      .err_o       (err_o)
   );

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Reference model: credit count, FIFO contents as a queue, expected registered outputs.
   int m_credits;
   bit m_err0, m_err1, m_lv, m_co;
   int m_ld;
   int q[$];
   int delivered[$];

   always @(negedge clk) begin
      bit send, pop, was_full;
      if (rst) begin
         m_credits = N; m_err0 = 0; m_err1 = 0; m_lv = 0; m_co = 0; m_ld = 0;
         q.delete();
         delivered.delete();
      end
      check("ready_o", int'(ready_o), int'(m_credits != 0));
      check("credits_o", int'(credits_o), m_credits);
      check("link_valid_o", int'(link_valid_o), int'(m_lv));
      check("link_data_o", int'(link_data_o), m_ld);
      check("credit_o", int'(credit_o), int'(m_co));
      check("valid_o", int'(valid_o), int'(q.size() != 0));
      check("data_o", int'(data_o), (q.size() != 0) ? q[0] : 0);
      check("err_o", int'(err_o), {m_err1, m_err0});
      if (!rst) begin
         send     = valid_i && (m_credits != 0);
         pop      = (q.size() != 0) && ready_i;
         was_full = (q.size() == N);
         m_lv = send;
         if (send) m_ld = int'(data_i);
         if (send && !credit_i) m_credits--;
         else if (credit_i && !send) begin
            if (m_credits == N) m_err0 = 1;
            else m_credits++;
         end
         if (pop) begin
            delivered.push_back(int'(data_o));
            void'(q.pop_front());
         end
         if (link_valid_i) begin
            if (was_full && !pop) m_err1 = 1;
            else q.push_back(int'(link_data_i));
         end
         m_co = pop;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   task automatic check_delivered(input string name, input int first, input int count);
      check({name, "_count"}, delivered.size(), count);
      for (int i = 0; i < count; i++)
         check(name, (i < delivered.size()) ? delivered[i] : -1, first + i);
   endtask

   // Loopback body: advance the TX data index whenever a send lands on the edge.
   task automatic tx_cycles(input int n, inout int idx, inout int sent, input int last);
      bit s;
      for (int c = 0; c < n; c++) begin
         s = valid_i && ready_o;
         step(1);
         if (s) begin
            sent++;
            idx++;
            data_i = flit_t'(idx);
            if (idx > last) valid_i = 1'b0;
         end
      end
   endtask

   initial begin
      int idx, sent;
      rst = 1'b1; loop = 1'b0; valid_i = 1'b0; data_i = '0; ready_i = 1'b0;
      rx_valid_drv = 1'b0; rx_data_drv = '0; credit_drv = 1'b0;
      step(3);
      rst = 1'b0;

      // Reset state
      check("rst_credits", int'(credits_o), 4);
      check("rst_ready", int'(ready_o), 1);
      check("rst_link_valid", int'(link_valid_o), 0);
      check("rst_credit_o", int'(credit_o), 0);
      check("rst_valid_o", int'(valid_o), 0);
      check("rst_err", int'(err_o), 0);

      // Loopback: four flits fill the far buffer, fifth waits for a credit
      loop = 1'b1; valid_i = 1'b1; idx = 1; sent = 0; data_i = 8'd1;
      tx_cycles(8, idx, sent, 5);
      check("lb_sent4", sent, 4);
      check("lb_credits0", int'(credits_o), 0);
      check("lb_ready0", int'(ready_o), 0);
      check("lb_head", int'(data_o), 1);
      ready_i = 1'b1;
      tx_cycles(40, idx, sent, 5);
      check("lb_sent5", sent, 5);
      check_delivered("lb_order", 1, 5);
      check("lb_credits4", int'(credits_o), 4);
      check("lb_err", int'(err_o), 0);
      ready_i = 1'b0; loop = 1'b0; valid_i = 1'b0;

      // TX standalone: credit arriving while empty does not enable a same-cycle send
      do_reset();
      valid_i = 1'b1; data_i = 8'h10;
      step(4);
      check("tx_credits0", int'(credits_o), 0);
      credit_drv = 1'b1;
      step(1);
      credit_drv = 1'b0;
      check("tx_credits1", int'(credits_o), 1);
      check("tx_nosend", int'(link_valid_o), 0);
      credit_drv = 1'b1; data_i = 8'h20;
      step(1);
      credit_drv = 1'b0; valid_i = 1'b0;
      check("tx_both_credits", int'(credits_o), 1);
      check("tx_both_send", int'(link_valid_o), 1);
      check("tx_both_data", int'(link_data_o), 32);
      step(1);

      // Credit overflow at full credits is sticky
      do_reset();
      credit_drv = 1'b1;
      step(1);
      credit_drv = 1'b0;
      check("ovf_credits", int'(credits_o), 4);
      check("ovf_err", int'(err_o), 1);
      step(10);
      check("ovf_sticky", int'(err_o), 1);

      // RX overflow: fifth push without pop is dropped
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         rx_valid_drv = 1'b1; rx_data_drv = flit_t'(i);
         step(1);
      end
      rx_valid_drv = 1'b0;
      check("rxo_err", int'(err_o), 2);
      check("rxo_head", int'(data_o), 1);
      check("rxo_valid", int'(valid_o), 1);
      ready_i = 1'b1;
      step(6);
      ready_i = 1'b0;
      check_delivered("rxo_order", 1, 4);
      check("rxo_sticky", int'(err_o), 2);

      // RX full with simultaneous pop: push accepted
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         rx_valid_drv = 1'b1; rx_data_drv = flit_t'(i);
         if (i == 5) ready_i = 1'b1;
         step(1);
      end
      rx_valid_drv = 1'b0;
      check("rxp_err", int'(err_o), 0);
      step(6);
      ready_i = 1'b0;
      check_delivered("rxp_order", 1, 5);

      // Reset mid-operation with buffered flits and outstanding credits
      do_reset();
      valid_i = 1'b1; rx_valid_drv = 1'b1;
      data_i = 8'h31; rx_data_drv = 8'd7;
      step(1);
      data_i = 8'h32; rx_data_drv = 8'd8;
      step(1);
      valid_i = 1'b0; rx_valid_drv = 1'b0;
      check("mid_valid_pre", int'(valid_o), 1);
      check("mid_credits_pre", int'(credits_o), 2);
      do_reset();
      check("mid_valid", int'(valid_o), 0);
      check("mid_credits", int'(credits_o), 4);
      check("mid_credit_o", int'(credit_o), 0);
      check("mid_link_valid", int'(link_valid_o), 0);
      loop = 1'b1; ready_i = 1'b1; valid_i = 1'b1; data_i = 8'h41; idx = 65; sent = 0;
      tx_cycles(10, idx, sent, 66);
      check("mid_sent", sent, 2);
      check_delivered("mid_order", 65, 2);
      check("mid_credits_end", int'(credits_o), 4);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
